// File: rtl/attempt_guard.sv
// Failed-attempt guard: counts consecutive password mismatches, locks entry out for a while.
// Optional auto-relock of an open lock is enabled by defining ATTEMPT_GUARD_AUTO_RELOCK_EN.
module attempt_guard #(
  parameter int MAX_FAIL      = 3,
  parameter int LOCK_CYCLES   = 1000,
  parameter int RELOCK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        chk_valid,
  input  logic        chk_match,
  input  logic        close,
  output logic        entry_en,
  output logic        open_st,
  output logic        lockout,
  output logic        relock,
  output logic [2:0]  fail_cnt,
  output logic [15:0] timer,
  output logic [4:0]  led
);

  if (MAX_FAIL < 1 || MAX_FAIL > 7) begin : g_bad_max_fail
    $error("attempt_guard: MAX_FAIL must be 1..7");
  end
  if (LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : g_bad_lock
    $error("attempt_guard: LOCK_CYCLES must be 1..65535");
  end
  if (RELOCK_CYCLES < 1 || RELOCK_CYCLES > 65535) begin : g_bad_relock
    $error("attempt_guard: RELOCK_CYCLES must be 1..65535");
  end

  localparam logic [2:0]  MAX_F     = 3'(MAX_FAIL);
  localparam logic [15:0] LOCK_LD   = 16'(LOCK_CYCLES - 1);
  localparam logic [15:0] RELOCK_LD = 16'(RELOCK_CYCLES - 1);

  // One-hot so the status outputs come straight off state flops.
  typedef enum logic [2:0] {
    READY   = 3'b001,
    OPEN    = 3'b010,
    LOCKOUT = 3'b100
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  fail_q, fail_d;
  logic [15:0] timer_q, timer_d;
  logic        relock_q, relock_d;
  logic [2:0]  fail_inc;

  assign fail_inc = fail_q + 3'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= READY;
      fail_q   <= 3'd0;
      timer_q  <= 16'd0;
      relock_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fail_q   <= fail_d;
      timer_q  <= timer_d;
      relock_q <= relock_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fail_d   = fail_q;
    timer_d  = timer_q;
    relock_d = 1'b0;
    case (state_q)
      READY: begin
        if (chk_valid) begin
          if (chk_match) begin
            state_d = OPEN;
            fail_d  = 3'd0;
`ifdef ATTEMPT_GUARD_AUTO_RELOCK_EN
            timer_d = RELOCK_LD;
`endif
          end else if (fail_inc == MAX_F) begin
            state_d = LOCKOUT;
            fail_d  = MAX_F;
            timer_d = LOCK_LD;
          end else begin
            fail_d  = fail_inc;
          end
        end
      end
      OPEN: begin
        // close takes priority over an expiry in the same cycle
        if (close) begin
          state_d = READY;
          timer_d = 16'd0;
        end
`ifdef ATTEMPT_GUARD_AUTO_RELOCK_EN
        else if (timer_q == 16'd0) begin
          state_d  = READY;
          relock_d = 1'b1;
        end else begin
          timer_d = timer_q - 16'd1;
        end
`endif
      end
      LOCKOUT: begin
        if (timer_q == 16'd0) begin
          state_d = READY;
          fail_d  = 3'd0;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: begin
        state_d = READY;
        fail_d  = 3'd0;
        timer_d = 16'd0;
      end
    endcase
  end

  assign entry_en = state_q[0];
  assign open_st  = state_q[1];
  assign lockout  = state_q[2];
  assign relock   = relock_q;
  assign fail_cnt = fail_q;
  assign timer    = timer_q;
  assign led      = {fail_q[1:0], state_q[2], state_q[1], state_q[0]};

endmodule

// File: tb/tb_attempt_guard.sv
// Bench for attempt_guard: directed scenarios plus random traffic against a rule-level model.
module tb_attempt_guard;
  localparam int MF = 3, LC = 8, RC = 5;
`ifdef ATTEMPT_GUARD_AUTO_RELOCK_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic chk_valid = 1'b0, chk_match = 1'b0, close = 1'b0;
  logic entry_en, open_st, lockout, relock;
  logic [2:0]  fail_cnt;
  logic [15:0] timer;
  logic [4:0]  led;

  attempt_guard #(.MAX_FAIL(MF), .LOCK_CYCLES(LC), .RELOCK_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .chk_valid(chk_valid), .chk_match(chk_match), .close(close),
    .entry_en(entry_en), .open_st(open_st), .lockout(lockout), .relock(relock),
    .fail_cnt(fail_cnt), .timer(timer), .led(led)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  // model: mode 0=ready 1=open 2=lockout; remain = cycles left on active countdown
  int m_mode, m_fails, m_remain, m_relock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_fails = 0; m_remain = 0; m_relock = 0;
  endtask

  task automatic model_step(input bit v, input bit m, input bit c);
    m_relock = 0;
    if (m_mode == 0) begin
      if (v && m) begin
        m_mode = 1; m_fails = 0; m_remain = AUTO ? RC - 1 : 0;
      end else if (v) begin
        m_fails++;
        if (m_fails == MF) begin m_mode = 2; m_remain = LC - 1; end
      end
    end else if (m_mode == 1) begin
      if (c) begin m_mode = 0; m_remain = 0; end
      else if (AUTO) begin
        if (m_remain == 0) begin m_mode = 0; m_relock = 1; end
        else m_remain--;
      end
    end else begin
      if (m_remain == 0) begin m_mode = 0; m_fails = 0; end
      else m_remain--;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".entry_en"}, entry_en, m_mode == 0);
    chk({tag, ".open_st"},  open_st,  m_mode == 1);
    chk({tag, ".lockout"},  lockout,  m_mode == 2);
    chk({tag, ".relock"},   relock,   m_relock);
    chk({tag, ".fail_cnt"}, fail_cnt, m_fails);
    chk({tag, ".timer"},    timer,    m_remain);
    chk({tag, ".led"},      led, {m_fails[1:0], m_mode == 2, m_mode == 1, m_mode == 0});
    chk({tag, ".onehot"},   32'(entry_en) + 32'(open_st) + 32'(lockout), 1);
  endtask

  // apply inputs at negedge, clock once, compare everything at the following negedge
  task automatic step(input string tag, input bit v, input bit m, input bit c);
    chk_valid = v; chk_match = m; close = c;
    @(posedge clk);
    if (rst) model_step(v, m, c); else model_reset();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    model_reset();
    @(negedge clk); @(negedge clk);
    check_all("reset");
    chk("reset.led_const", led, 5'b00001);
    rst = 1'b1;
    step("idle", 0, 0, 0);

    // lockout
    step("lk1", 1, 0, 0); chk("lk1.fail", fail_cnt, 1);
    step("lk2", 1, 0, 0); chk("lk2.fail", fail_cnt, 2);
    step("lk3", 1, 0, 0); chk("lk3.fail", fail_cnt, 3);
    chk("lk3.lockout", lockout, 1); chk("lk3.timer", timer, 7);

    // lockout expiry, with ignored checks/close along the way
    for (int i = 0; i < 7; i++) begin
      step("lkx", i % 2 == 0, i % 3 == 0, i % 2 == 1);
      chk("lkx.lockout", lockout, 1);
      chk("lkx.timer", timer, 6 - i);
    end
    step("lkend", 0, 0, 0);
    chk("lkend.entry", entry_en, 1); chk("lkend.fail", fail_cnt, 0);
    chk("lkend.timer", timer, 0);

    // match resets history
    step("mr1", 1, 0, 0); step("mr2", 1, 0, 0);
    step("mr3", 1, 1, 0);
    chk("mr3.open", open_st, 1); chk("mr3.fail", fail_cnt, 0);
    step("mr_close", 0, 0, 1); chk("mr_close.entry", entry_en, 1);
    step("mr_idle", 0, 0, 0);

    if (AUTO) begin
      step("ar_m", 1, 1, 0); chk("ar_m.timer", timer, RC - 1);
      for (int i = 0; i < RC - 1; i++) begin
        step("ar_w", 0, 0, 0); chk("ar_w.open", open_st, 1);
      end
      step("ar_exp", 0, 0, 0);
      chk("ar_exp.relock", relock, 1); chk("ar_exp.entry", entry_en, 1);
      step("ar_after", 0, 0, 0); chk("ar_after.relock", relock, 0);
      step("arc_m", 1, 1, 0);
      for (int i = 0; i < RC - 1; i++) step("arc_w", 0, 0, 0);
      step("arc_exp", 0, 0, 1);
      chk("arc_exp.relock", relock, 0); chk("arc_exp.entry", entry_en, 1);
      step("arc_idle", 0, 0, 0);
    end else begin
      step("nr_m", 1, 1, 0);
      for (int i = 0; i < 100; i++) step("nr_w", 0, 0, 0);
      chk("nr.open", open_st, 1); chk("nr.relock", relock, 0); chk("nr.timer", timer, 0);
      step("nr_close", 0, 0, 1); chk("nr_close.entry", entry_en, 1);
      step("nr_idle", 0, 0, 0);
    end

    // async reset mid-lockout at timer=4
    step("rl1", 1, 0, 0); step("rl2", 1, 0, 0); step("rl3", 1, 0, 0);
    step("rl4", 0, 0, 0); step("rl5", 0, 0, 0); step("rl6", 0, 0, 0);
    chk("rl.timer4", timer, 4);
    #1 rst = 1'b0;
    #1 model_reset();
    check_all("rl_async");
    chk("rl_async.led_const", led, 5'b00001);
    step("rl_hold", 1, 0, 0);
    rst = 1'b1;
    step("rl_f1", 1, 0, 0); step("rl_f2", 1, 0, 0);
    chk("rl_f2.lockout", lockout, 0); chk("rl_f2.fail", fail_cnt, 2);
    step("rl_idle", 0, 0, 0);

    // random traffic, occasional async reset
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b0;
        #1 model_reset();
        check_all("rnd_rst");
        step("rnd_rsthold", 0, 0, 0);
        rst = 1'b1;
      end
      step("rnd", $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/attempt_guard.md
ATTEMPT_GUARD -- requirements
Module: attempt_guard

Interface
REQ-001 The block SHALL have parameter MAX_FAIL, default 3, consecutive failed checks that trigger lockout (legal range 1..7).
REQ-002 The block SHALL have parameter LOCK_CYCLES, default 1000, lockout duration in clk cycles (legal range 1..65535).
REQ-003 The block SHALL have parameter RELOCK_CYCLES, default 500, auto-relock delay in clk cycles while open (legal range 1..65535).
REQ-004 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port chk_valid, input, 1, one-cycle pulse: password comparison result is valid.
REQ-007 The block SHALL have port chk_match, input, 1, comparison result, sampled only when chk_valid=1 (1=match).
REQ-008 The block SHALL have port close, input, 1, user request to close the lock, level, sampled every cycle.
REQ-009 The block SHALL have port entry_en, output, 1, 1 = lock FSM may accept digit entry.
REQ-010 The block SHALL have port open_st, output, 1, 1 = lock is open.
REQ-011 The block SHALL have port lockout, output, 1, 1 = entry blocked after too many failures.
REQ-012 The block SHALL have port relock, output, 1, one-cycle pulse on auto-relock.
REQ-013 The block SHALL have port fail_cnt, output, 3, current consecutive failure count.
REQ-014 The block SHALL have port timer, output, 16, remaining cycles of the active countdown, 0 when none is active.
REQ-015 The block SHALL have port led, output, 5, status LEDs: {fail_cnt[1:0], lockout, open_st, entry_en}.

Function
REQ-016 The block SHALL implement states READY, OPEN and LOCKOUT, with all outputs registered.
REQ-017 Outputs SHALL reflect a transition one cycle after the triggering input edge.
REQ-018 In READY, chk_valid=1 with chk_match=1 SHALL go to OPEN and clear fail_cnt to 0.
REQ-019 In READY, chk_valid=1 with chk_match=0 SHALL increment fail_cnt.
REQ-020 If that increment makes fail_cnt equal MAX_FAIL, the block SHALL go to LOCKOUT with timer=LOCK_CYCLES-1.
REQ-021 In LOCKOUT, the block SHALL decrement timer by 1 per cycle, ignore chk_valid and close, and hold fail_cnt at MAX_FAIL.
REQ-022 In LOCKOUT with timer=0, the block SHALL go to READY on the next edge, with fail_cnt cleared and timer held at 0.
REQ-023 In OPEN, close=1 SHALL return the block to READY; chk_valid SHALL be ignored.
REQ-024 In READY, close SHALL be ignored.
REQ-025 Outputs SHALL be entry_en=1 only in READY, open_st=1 only in OPEN, and lockout=1 only in LOCKOUT; exactly one is 1 at any time.
REQ-026 The timer SHALL saturate at 0 and never wrap.
REQ-027 fail_cnt SHALL never exceed MAX_FAIL.
REQ-028 With LOCK_CYCLES=1, LOCKOUT SHALL last exactly one cycle.
REQ-029 Illegal parameter values SHALL cause an elaboration-time error.

Reset
REQ-030 While rst=0, the block SHALL immediately force state=READY, fail_cnt=0, timer=0, entry_en=1, open_st=0, lockout=0, relock=0 and led=5'b00001.
REQ-031 Reset asserted mid-LOCKOUT or mid-OPEN SHALL abort the countdown and discard the failure history.
REQ-032 After rst deasserts, the first state change SHALL occur no earlier than the first following clk edge.

Configuration
REQ-033 When macro ATTEMPT_GUARD_AUTO_RELOCK_EN is defined, entry to OPEN SHALL load timer=RELOCK_CYCLES-1 and decrement it each cycle in OPEN.
REQ-034 With the macro defined and timer=0 in OPEN, the block SHALL go to READY and pulse relock=1 for exactly one cycle.
REQ-035 With the macro defined, close=1 in the same cycle as expiry SHALL go to READY with relock=0, so close wins.
REQ-036 When the macro is undefined, OPEN SHALL be left only by close or reset, timer SHALL read 0 in OPEN, and relock SHALL be tied to 0.

Verification
REQ-037 The bench SHALL run with MAX_FAIL=3, LOCK_CYCLES=8 and RELOCK_CYCLES=5.
REQ-038 Scenario "lockout": three pulses chk_valid=1, chk_match=0 from READY -> fail_cnt 1,2,3; lockout=1 one cycle after the third; timer=7.
REQ-039 Scenario "lockout expiry": continue from lockout -> lockout stays 1 for 8 cycles with timer counting 7..0, then entry_en=1, fail_cnt=0; chk_valid pulses during LOCKOUT change nothing.
REQ-040 Scenario "match resets history": two failures, then a match -> open_st=1, fail_cnt=0; close=1 -> entry_en=1 next cycle.
REQ-041 Scenario "auto-relock" (macro defined): match, then no close -> open_st=1 for 5 cycles, then relock pulses once, entry_en=1; with close on the expiry cycle -> relock stays 0.
REQ-042 Scenario "no auto-relock" (macro undefined): match, then 100 cycles with no close -> open_st stays 1, relock=0, timer=0.
REQ-043 Scenario "reset mid-lockout": rst=0 asynchronously mid-lockout at timer=4 -> all outputs at reset values without a clk edge; after release, two failures do not trigger lockout.
